// File: rtl/rob_gen2.sv
// rob_gen2: N-wide reorder buffer with in-group squash truncation, resolved
// redirect target and a terminal halt state.
module rob_gen2 #(
   parameter int DEPTH      = 32,
   parameter int DISPATCH_W = 2,
   parameter int CMPL_W     = 3,
   parameter int COMMIT_W   = 2,
   parameter int PAYLOAD_W  = 64,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic [DISPATCH_W-1:0]           i_dis_valid,
   input  logic [DISPATCH_W*PAYLOAD_W-1:0] i_dis_payload,
   input  logic [DISPATCH_W-1:0]           i_dis_halt,
   output logic                            o_dis_ready,
   output logic [DISPATCH_W*IDX_W-1:0]     o_dis_idx,
   input  logic [CMPL_W-1:0]               i_cmpl_valid,
   input  logic [CMPL_W*IDX_W-1:0]         i_cmpl_idx,
   input  logic [CMPL_W-1:0]               i_cmpl_mispredict,
   input  logic [CMPL_W*32-1:0]            i_cmpl_target,
   output logic [COMMIT_W-1:0]             o_ct_valid,
   output logic [COMMIT_W*PAYLOAD_W-1:0]   o_ct_payload,
   output logic                            o_squash,
   output logic [31:0]                     o_squash_target,
   output logic                            o_halted,
   output logic [IDX_W:0]                  o_count
);
   typedef enum logic [1:0] {EMPTY, DISPATCHED, COMPLETED} ent_e;
   typedef enum logic {RUN, HALTED} fsm_e;
   localparam logic [IDX_W:0] L_DEPTH = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] L_DW    = (IDX_W+1)'(DISPATCH_W);
   localparam logic [IDX_W:0] L_ONE   = (IDX_W+1)'(1);
   ent_e                 r_st  [DEPTH];
   logic [PAYLOAD_W-1:0] r_pay [DEPTH];
   logic [31:0]          r_tgt [DEPTH];
   logic [DEPTH-1:0]     r_hlt, r_mis;
   logic [IDX_W-1:0]     r_head, r_tail;
   logic [IDX_W:0]       r_count;
   fsm_e                 r_state, w_state_nxt;
   logic                 w_run, w_chain, w_halt_ct;
   logic [IDX_W:0]       w_n_dis, w_n_ct;
   logic [IDX_W-1:0]     w_ct_idx [COMMIT_W];

   always_ff @(posedge i_clock)
      r_state <= i_reset ? RUN : w_state_nxt;

   always_comb
      w_state_nxt = (r_state == RUN && w_halt_ct) ? HALTED : r_state;

   always_comb begin
      w_run       = r_state == RUN;
      o_halted    = !w_run;
      o_dis_ready = w_run && (L_DEPTH - r_count >= L_DW);
   end

   always_comb begin
      o_dis_idx = '0;
      w_n_dis   = '0;
      for (int i = 0; i < DISPATCH_W; i++) begin
         o_dis_idx[i*IDX_W +: IDX_W] = r_tail + IDX_W'(i);
         w_n_dis = (o_dis_ready && i_dis_valid[i]) ? w_n_dis + L_ONE : w_n_dis;
      end
   end

   // The commit group stops after the first mispredicted or halt entry.
   always_comb begin
      w_chain         = w_run;
      o_ct_valid      = '0;
      o_ct_payload    = '0;
      o_squash        = 1'b0;
      o_squash_target = '0;
      w_halt_ct       = 1'b0;
      w_n_ct          = '0;
      for (int j = 0; j < COMMIT_W; j++) begin
         w_ct_idx[j] = r_head + IDX_W'(j);
         w_chain = w_chain && r_st[w_ct_idx[j]] == COMPLETED;
         o_ct_valid[j] = w_chain;
         if (w_chain) begin
            o_ct_payload[j*PAYLOAD_W +: PAYLOAD_W] = r_pay[w_ct_idx[j]];
            w_n_ct = w_n_ct + L_ONE;
            if (r_mis[w_ct_idx[j]]) begin
               o_squash        = 1'b1;
               o_squash_target = r_tgt[w_ct_idx[j]];
            end
            w_halt_ct = w_halt_ct || r_hlt[w_ct_idx[j]];
         end
         w_chain = w_chain && !r_mis[w_ct_idx[j]] && !r_hlt[w_ct_idx[j]];
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || o_squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int d = 0; d < DEPTH; d++)
            r_st[d] <= EMPTY;
      end else begin
         r_head  <= r_head + w_n_ct[IDX_W-1:0];
         r_tail  <= r_tail + w_n_dis[IDX_W-1:0];
         r_count <= r_count + w_n_dis - w_n_ct;
         for (int j = 0; j < COMMIT_W; j++)
            if (o_ct_valid[j]) r_st[w_ct_idx[j]] <= EMPTY;
         for (int k = 0; k < CMPL_W; k++)
            if (i_cmpl_valid[k] && r_st[i_cmpl_idx[k*IDX_W +: IDX_W]] == DISPATCHED)
               r_st[i_cmpl_idx[k*IDX_W +: IDX_W]] <= COMPLETED;
         for (int i = 0; i < DISPATCH_W; i++)
            if (o_dis_ready && i_dis_valid[i]) r_st[o_dis_idx[i*IDX_W +: IDX_W]] <= DISPATCHED;
      end
   end

   // Entry data needs no reset: it is only observed through a non-EMPTY state.
   always_ff @(posedge i_clock) begin
      for (int k = 0; k < CMPL_W; k++)
         if (i_cmpl_valid[k] && r_st[i_cmpl_idx[k*IDX_W +: IDX_W]] == DISPATCHED) begin
            r_mis[i_cmpl_idx[k*IDX_W +: IDX_W]] <= i_cmpl_mispredict[k];
            r_tgt[i_cmpl_idx[k*IDX_W +: IDX_W]] <= i_cmpl_target[k*32 +: 32];
         end
      for (int i = 0; i < DISPATCH_W; i++)
         if (o_dis_ready && i_dis_valid[i]) begin
            r_pay[o_dis_idx[i*IDX_W +: IDX_W]] <= i_dis_payload[i*PAYLOAD_W +: PAYLOAD_W];
            r_hlt[o_dis_idx[i*IDX_W +: IDX_W]] <= i_dis_halt[i];
         end
   end

   assign o_count = r_count;

   for (genvar a = 0; a < CMPL_W; a++) begin : g_a
      for (genvar b = a + 1; b < CMPL_W; b++) begin : g_b
         a_cmpl_uniq: assert property (@(posedge i_clock) disable iff (i_reset)
            !(i_cmpl_valid[a] && i_cmpl_valid[b] &&
              i_cmpl_idx[a*IDX_W +: IDX_W] == i_cmpl_idx[b*IDX_W +: IDX_W]));
      end
   end
endmodule
